// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-wide data memory responder with byte strobes, read rotation and wait states
module dmem_responder #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req,
   input  logic [31:0] data_addr,
   input  logic [3:0]  dmem_wr,
   input  logic [31:0] wr_data,
   output logic        ready,
   output logic [31:0] rd_data,
   output logic        err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   // The wait counter is only 4 bits wide, so larger settings cannot be honoured.
   generate
      if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
         $error("dmem_responder: WAIT_STATES must be in 0..15");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t       state;
   logic [3:0]   cnt;
   logic [31:0]  addr_q;
   logic [31:0]  data_q;
   logic [3:0]   strb_q;
   logic [31:0]  mem [DEPTH];

   logic         accept;
   logic         enter_resp;
   logic         oor;
   logic [31:0]  cur_addr;
   logic [31:0]  cur_data;
   logic [3:0]   cur_strb;
   logic [AW-1:0] idx;
   logic [31:0]  word;
   logic [31:0]  rot;

   // With zero wait states the access happens on the accept edge itself, so the
   // live request fields are used instead of the not-yet-loaded latches.
   assign accept     = (state == S_IDLE) && req;
   assign enter_resp = (accept && (WAIT_STATES == 0)) || ((state == S_WAIT) && (cnt == 4'd0));
   assign cur_addr   = accept ? data_addr : addr_q;
   assign cur_data   = accept ? wr_data   : data_q;
   assign cur_strb   = accept ? dmem_wr   : strb_q;
   assign idx        = cur_addr[AW+1:2];
   assign oor        = |cur_addr[31:AW+2];
   assign word       = mem[idx];

   // Rotate the addressed word right so the addressed byte lands at bit 0.
   always_comb begin
      rot = word;
      case (cur_addr[1:0])
         2'd0: rot = word;
         2'd1: rot = {word[7:0],  word[31:8]};
         2'd2: rot = {word[15:0], word[31:16]};
         2'd3: rot = {word[23:0], word[31:24]};
         default: rot = word;
      endcase
   end

   // Hold the request fields for the duration of the wait states.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q <= data_addr;
         data_q <= wr_data;
         strb_q <= dmem_wr;
      end
   end

   // Byte-lane write commit on the edge entering RESP; reset suppresses it.
   always_ff @(posedge clk) begin
      if (rstn && enter_resp && !oor) begin
         for (int i = 0; i < 4; i++) begin
            if (cur_strb[i]) begin
               mem[idx][8*i +: 8] <= cur_data[8*i +: 8];
            end
         end
      end
   end

   // Request FSM with registered ready/err/rd_data.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         ready   <= 1'b0;
         err     <= 1'b0;
         rd_data <= 32'h0;
      end else begin
         ready <= 1'b0;
         err   <= 1'b0;
         if (enter_resp) begin
            ready <= 1'b1;
            err   <= oor;
            if (oor) begin
               rd_data <= 32'h0;
            end else if (cur_strb == 4'b0000) begin
               rd_data <= rot;
            end
         end
         case (state)
            S_IDLE: begin
               if (req) begin
                  cnt   <= WS_LOAD;
                  state <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
               end
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd0) begin
                  state <= S_RESP;
               end
            end
            S_RESP: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
